// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply / 32/32 divide unit producing HI/LO results.
// Both operations run on operand magnitudes for 32 cycles, then apply sign correction
// in one extra cycle that also loads HI/LO and enters FINISH.
// A divide by zero passes through DIV for one cycle without iterating.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_div,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam int unsigned W    = 32;
  localparam int unsigned W2   = 64;
  localparam int unsigned ITER = 32;
  localparam int unsigned CW   = 6;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   acc_hi_q, acc_hi_d;
  logic [W-1:0]   acc_lo_q, acc_lo_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic           neg_q, neg_d;
  logic           neg_rem_q, neg_rem_d;
  logic           dz_pend_q, dz_pend_d;
  logic [W-1:0]   hi_d, lo_d;
  logic           busy_d, done_d, div_zero_d;

  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W+1:0]   div_trial;
  logic           div_borrow;
  logic [W2-1:0]  prod, prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  // Operand magnitudes, one iteration step of each algorithm, and final sign fix-up
  always_comb begin
    mag_a      = A_in[W-1] ? (~A_in + W'(1)) : A_in;
    mag_b      = B_in[W-1] ? (~B_in + W'(1)) : B_in;
    mul_sum    = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : W'(0))};
    div_shift  = {acc_hi_q, acc_lo_q[W-1]};
    div_trial  = {1'b0, div_shift} - {2'b00, opnd_q};
    div_borrow = div_trial[W+1];
    prod       = {acc_hi_q, acc_lo_q};
    prod_fix   = neg_q ? (~prod + W2'(1)) : prod;
    quot_fix   = neg_q ? (~acc_lo_q + W'(1)) : acc_lo_q;
    rem_fix    = neg_rem_q ? (~acc_hi_q + W'(1)) : acc_hi_q;
  end

  // Next-state and next-value logic for the control FSM and datapath registers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dz_pend_d  = dz_pend_q;
    hi_d       = HI_out;
    lo_d       = LO_out;
    busy_d     = busy;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = op_div ? S_DIV : S_MULT;
          cnt_d     = '0;
          busy_d    = 1'b1;
          acc_hi_d  = '0;
          acc_lo_d  = op_div ? mag_a : mag_b;
          opnd_d    = op_div ? mag_b : mag_a;
          neg_d     = A_in[W-1] ^ B_in[W-1];
          neg_rem_d = A_in[W-1];
          dz_pend_d = op_div && (B_in == '0);
        end
      end
      S_MULT: begin
        if (cnt_q == CW'(ITER)) begin
          hi_d    = prod_fix[W2-1:W];
          lo_d    = prod_fix[W-1:0];
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          acc_hi_d = mul_sum[W:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
          cnt_d    = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        if (dz_pend_q) begin
          done_d     = 1'b1;
          div_zero_d = 1'b1;
          state_d    = S_FINISH;
        end else if (cnt_q == CW'(ITER)) begin
          hi_d    = rem_fix;
          lo_d    = quot_fix;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          acc_hi_d = div_borrow ? div_shift[W-1:0] : div_trial[W-1:0];
          acc_lo_d = {acc_lo_q[W-2:0], ~div_borrow};
          cnt_d    = cnt_q + CW'(1);
        end
      end
      S_FINISH: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        dz_pend_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      HI_out    <= '0;
      LO_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
      HI_out    <= hi_d;
      LO_out    <= lo_d;
      busy      <= busy_d;
      done      <= done_d;
      div_zero  <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_div;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_pass;
  int n_total;
  logic [31:0] corners [5];

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_div   (op_div),
    .A_in     (A_in),
    .B_in     (B_in),
    .HI_out   (HI_out),
    .LO_out   (LO_out),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full signed product as {HI, LO}
  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Reference: {remainder, quotient} with truncation toward zero
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  // Issue one operation and wait for done; lat is edges after the start edge, -1 on timeout
  task automatic do_op(input bit sync_first, input bit div, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    if (sync_first) @(negedge clk);
    start = 1'b1; op_div = div; A_in = a; B_in = b;
    @(negedge clk);
    start = 1'b0; A_in = $urandom; B_in = $urandom; op_div = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op_div = 1'b0; A_in = 32'd9; B_in = 32'd9;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    n_total++;
    if ({busy, done, div_zero} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {busy, done, div_zero});
    else n_pass++;
    n_total++;
    if ({HI_out, LO_out} !== 64'd0) $display("FAIL reset_hilo got=%h exp=0", {HI_out, LO_out});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_start_discarded busy=%b exp=0", busy);
    else n_pass++;
  endtask

  task automatic test_mult_vectors();
    int lat;
    do_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, lat);
    n_total++;
    if (lat !== 33) $display("FAIL mult_latency got=%0d exp=33", lat);
    else n_pass++;
    n_total++;
    if ({HI_out, LO_out, div_zero} !== {32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0})
      $display("FAIL mult_7x-3 got=%h_%h dz=%b exp=ffffffff_ffffffeb dz=0", HI_out, LO_out, div_zero);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL done_single_cycle got=%b exp=0", done);
    else n_pass++;
    do_op(1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, lat);
    n_total++;
    if ({HI_out, LO_out} !== {32'h3FFFFFFF, 32'h00000001})
      $display("FAIL mult_maxpos got=%h_%h exp=3fffffff_00000001", HI_out, LO_out);
    else n_pass++;
  endtask

  task automatic test_div_vectors();
    int lat;
    do_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, lat);
    n_total++;
    if (lat !== 33) $display("FAIL div_latency got=%0d exp=33", lat);
    else n_pass++;
    n_total++;
    if ({HI_out, LO_out} !== {32'hFFFFFFFF, 32'hFFFFFFFD})
      $display("FAIL div_-7/2 got=%h_%h exp=ffffffff_fffffffd", HI_out, LO_out);
    else n_pass++;
    do_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
    n_total++;
    if ({HI_out, LO_out, div_zero} !== {32'h0, 32'h80000000, 1'b0})
      $display("FAIL div_overflow got=%h_%h dz=%b exp=00000000_80000000 dz=0", HI_out, LO_out, div_zero);
    else n_pass++;
  endtask

  task automatic test_div_zero();
    int lat;
    logic [63:0] pre;
    do_op(1'b1, 1'b0, 32'h00012345, 32'hFFFF1000, lat);
    pre = ref_mult(32'h00012345, 32'hFFFF1000);
    do_op(1'b1, 1'b1, 32'd5, 32'd0, lat);
    n_total++;
    if (lat !== 1) $display("FAIL divzero_latency got=%0d exp=1", lat);
    else n_pass++;
    n_total++;
    if (div_zero !== 1'b1) $display("FAIL divzero_flag got=%b exp=1", div_zero);
    else n_pass++;
    n_total++;
    if ({HI_out, LO_out} !== pre) $display("FAIL divzero_hold got=%h exp=%h", {HI_out, LO_out}, pre);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({done, div_zero, busy} !== 3'b000) $display("FAIL divzero_after got=%b exp=000", {done, div_zero, busy});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    start = 1'b1; op_div = 1'b0; A_in = 32'h1234; B_in = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++;
    if ({busy, done, HI_out, LO_out} !== 66'd0)
      $display("FAIL reset_mid got busy=%b done=%b hilo=%h exp=0", busy, done, {HI_out, LO_out});
    else n_pass++;
    do_op(1'b1, 1'b0, 32'd3, 32'd4, lat);
    n_total++;
    if ({lat, HI_out, LO_out} !== {32'd33, 32'd0, 32'd12})
      $display("FAIL after_reset_mult lat=%0d got=%h_%h exp=33 00000000_0000000c", lat, HI_out, LO_out);
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    int ndone, lat;
    logic [63:0] res;
    ndone = 0; lat = -1; res = '0;
    @(negedge clk);
    start = 1'b1; op_div = 1'b1; A_in = 32'd100; B_in = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          res = {HI_out, LO_out};
        end
      end
      if (k == 1) A_in = 32'd0;
      if (k == 4) start = 1'b1;
      if (k == 5) start = 1'b0;
    end
    n_total++;
    if (ndone !== 1 || lat !== 33) $display("FAIL ignored_start done_count=%0d lat=%0d exp=1 33", ndone, lat);
    else n_pass++;
    n_total++;
    if (res !== {32'd2, 32'd14}) $display("FAIL ignored_start_result got=%h exp=00000002_0000000e", res);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] exp;
    do_op(1'b1, 1'b0, 32'd1000, 32'd1000, lat);
    start = 1'b1; op_div = 1'b1; A_in = 32'd50; B_in = 32'd5;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL finish_start_ignored busy=%b exp=0", busy);
    else n_pass++;
    do_op(1'b0, 1'b1, 32'hFFFFFC18, 32'd7, lat);
    exp = ref_div(32'hFFFFFC18, 32'd7);
    n_total++;
    if (lat !== 33 || {HI_out, LO_out} !== exp)
      $display("FAIL back_to_back lat=%0d got=%h exp=33 %h", lat, {HI_out, LO_out}, exp);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    bit div;
    logic [31:0] a, b;
    logic [63:0] exp;
    logic exp_dz;
    int exp_lat;
    exp = {HI_out, LO_out};
    for (int i = 0; i < 40; i++) begin
      div = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      exp_dz  = div && (b == 32'd0);
      exp_lat = exp_dz ? 1 : 33;
      if (!exp_dz) exp = div ? ref_div(a, b) : ref_mult(a, b);
      do_op(1'b1, div, a, b, lat);
      n_total++;
      if (lat !== exp_lat || div_zero !== exp_dz || {HI_out, LO_out} !== exp)
        $display("FAIL random_%0d op=%0d a=%h b=%h lat=%0d dz=%b got=%h exp lat=%0d dz=%b val=%h",
                 i, div, a, b, lat, div_zero, {HI_out, LO_out}, exp_lat, exp_dz, exp);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    corners = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h7FFFFFFF};
    reset = 1'b1; start = 1'b0; op_div = 1'b0; A_in = '0; B_in = '0;
    test_reset();
    test_mult_vectors();
    test_div_vectors();
    test_div_zero();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
